uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte producers (e.g. register-file dump, debug monitor, status reporter).
- Accepts one byte per valid/ready handshake, launches it on the UART TX core via tx_send, tracks completion through the core's tx_sent flag, then regrants.
- Sits between the requesters and the UART TX datapath/FSM.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- DATA_W, 8, payload width per requester.
- LAUNCH_TIMEOUT, 16, max cycles tx_send may be held waiting for tx_sent to fall before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- arb_en  input  1  1 = new grants allowed; 0 = finish in-flight byte, grant nothing new.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_W  packed payloads; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-cycle acceptance pulse to the granted requester.
- tx_send  output  1  start request to UART TX core.
- tx_data  output  DATA_W  byte to transmit, stable from grant until completion.
- tx_sent  input  1  core flag: 1 when core idle/just finished, 0 while a frame is in progress.
- grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester.
- busy  output  1  1 in any state other than ARB.
- err_timeout  output  1  one-cycle pulse on launch abort.

Behaviour:
- Reset (rst=0, async): state=ARB, req_ready=0, tx_send=0, tx_data=0, grant_id=0, busy=0, err_timeout=0, timeout counter=0, last_grant=NUM_REQ-1 (requester 0 has first priority). Reset mid-frame abandons the byte; the core has its own reset.
- States: ARB, LAUNCH, WAIT_DONE. All outputs registered.
- ARB:
  - If arb_en=1 and any req_valid: winner = first valid index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Same edge: tx_data<=req_data[winner], grant_id<=winner, last_grant<=winner, req_ready[winner]<=1 for exactly one cycle, tx_send<=1, go LAUNCH.
  - Otherwise stay in ARB with all pulses 0.
  - The byte is consumed at the req_ready pulse. Requester must hold data while valid and may change it the cycle after ready.
- LAUNCH:
  - tx_send held 1, counter increments each cycle.
  - tx_sent=0 sampled: tx_send<=0, counter<=0, go WAIT_DONE.
  - Counter reaches LAUNCH_TIMEOUT-1 with tx_sent still 1: tx_send<=0, err_timeout<=1 for one cycle, counter<=0, go ARB. The byte is dropped; no retry.
- WAIT_DONE:
  - tx_send=0. Wait for tx_sent=1, then go ARB.
  - A new grant can occur no earlier than the cycle after entering ARB, so the core has left its single-cycle sent state.
- Latency: valid request to req_ready = 1 cycle when in ARB. Minimum turnaround from completion to next tx_send = 1 cycle.
- arb_en=0 has no effect on LAUNCH/WAIT_DONE. It only blocks new grants in ARB.
- req_valid dropping after grant has no effect; the byte is already latched.
- Simultaneous requests: strict rotation. With all valid continuously, grants go 0,1,2,3,0,...
- Single persistent requester: granted back-to-back. No starvation of others because rotation always starts past last_grant.
- busy=1 exactly in LAUNCH and WAIT_DONE.
- Never more than one req_ready bit high. tx_send never high outside LAUNCH.

Decomposition:
- Shared package uart_pkg: state encodings for the arbiter (ARB=2'd0, LAUNCH=2'd1, WAIT_DONE=2'd2), UART constants (TX_IDLE/TX_START/TX_STOP levels), default DATA_W.
- One sub-module: rr_priority_pick (combinational NUM_REQ-wide round-robin picker: inputs req vector, last_grant; outputs winner index and any_valid). Reusable for a future RX-side dispatcher.

Test Plan:
- Reset then req_valid=4'b0001, req_data[0]=8'hA5, model core drops tx_sent 2 cycles after tx_send and raises it 20 cycles later -> req_ready=4'b0001 one cycle, tx_data=8'hA5, tx_send high exactly 2 cycles, return to ARB, busy low after tx_sent rises.
- All four valid with data 8'h10,8'h21,8'h32,8'h43 held -> grant_id sequence 0,1,2,3,0 and tx_data sequence 10,21,32,43,10.
- last_grant=1, then req_valid=4'b1001 -> grant 3 before 0.
- Core model never drops tx_sent, LAUNCH_TIMEOUT=16 -> tx_send high 16 cycles, err_timeout one-cycle pulse, state back to ARB, next request granted normally.
- arb_en falls during WAIT_DONE with req_valid=4'b0100 pending -> current frame completes, no req_ready until arb_en=1, then grant 2 next cycle.
- rst asserted in WAIT_DONE -> all outputs 0 immediately (asynchronously); after release, requester 0 wins first if valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// line levels and default payload width.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;
    localparam logic TX_STOP  = 1'b1;

    localparam int UART_DATA_W = 8;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_grant_i, wrapping modulo NUM_REQ (NUM_REQ must be a power of two).
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_valid_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        // i == NUM_REQ wraps back onto last_grant_i itself, so a lone
        // persistent requester is granted back-to-back.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last_grant_i + IDX_W'(i);
            if (!found && req_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
        any_valid_o = |req_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers: grant, launch via tx_send, track tx_sent, then regrant.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB       | idle; grant the next valid requester when arb_en=1
// LAUNCH    | tx_send held, waiting for the core to drop tx_sent
// WAIT_DONE | frame in progress, waiting for tx_sent to rise again
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int LAUNCH_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_send,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_sent,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               send_q, send_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   winner;
    logic               any_valid;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .winner_o     (winner),
        .any_valid_o  (any_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            cnt_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gid_q   <= '0;
            ready_q <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            ready_q <= ready_d;
            send_q  <= send_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gid_d   = gid_q;
        ready_d = '0;
        send_d  = send_q;
        data_d  = data_q;
        err_d   = 1'b0;

        unique case (state_q)
            ARB: begin
                send_d = 1'b0;
                if (arb_en && any_valid) begin
                    data_d  = req_data[winner*DATA_W +: DATA_W];
                    gid_d   = winner;
                    last_d  = winner;
                    ready_d = NUM_REQ'(1) << winner;
                    send_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!tx_sent) begin
                    send_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Core never acknowledged: drop the byte, no retry.
                    send_d  = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                send_d = 1'b0;
                if (tx_sent) begin
                    state_d = ARB;
                end
            end
            default: begin
                send_d  = 1'b0;
                cnt_d   = '0;
                state_d = ARB;
            end
        endcase

        busy_d = (state_d != ARB);
    end

    assign req_ready   = ready_q;
    assign tx_send     = send_q;
    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference model
// compared every cycle, a behavioural UART core, directed and random traffic.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int LT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arb_en = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic              tx_sent = 1'b1;
    logic [NR-1:0]     req_ready;
    logic              tx_send;
    logic [DW-1:0]     tx_data;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_timeout;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LAUNCH_TIMEOUT(LT)) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_sent     (tx_sent),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural UART core: drops tx_sent drop_dly cycles after seeing
    // tx_send, raises it done_dly cycles later; hang=1 never acknowledges.
    int drop_dly = 2;
    int done_dly = 20;
    bit hang = 0;
    bit cbusy = 0;
    int ccnt = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            tx_sent = 1'b1; cbusy = 0; ccnt = 0;
        end else if (!cbusy) begin
            if (tx_send && !hang) begin
                ccnt++;
                if (ccnt >= drop_dly) begin
                    tx_sent = 1'b0; cbusy = 1; ccnt = 0;
                end
            end else begin
                ccnt = 0;
            end
        end else begin
            ccnt++;
            if (ccnt >= done_dly) begin
                tx_sent = 1'b1; cbusy = 0; ccnt = 0;
            end
        end
    end

    // Reference model: phase 0 idle, 1 launching (age cycles so far), 2 in frame.
    int            m_phase = 0;
    int            m_age = 0;
    int            m_last = NR - 1;
    logic [NR-1:0] e_ready = '0;
    logic          e_send = 1'b0;
    logic          e_err = 1'b0;
    logic [DW-1:0] e_data = '0;
    logic [1:0]    e_gid = '0;

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            m_phase = 0; m_age = 0; m_last = NR - 1;
            e_ready = '0; e_send = 0; e_err = 0; e_data = '0; e_gid = '0;
        end else begin
            e_ready = '0;
            e_err   = 1'b0;
            if (m_phase == 0) begin
                int w;
                w = rr_pick(req_valid, m_last);
                if (arb_en && w >= 0) begin
                    m_last = w;
                    e_gid = 2'(w);
                    e_data = req_data[w*DW +: DW];
                    e_ready[w] = 1'b1;
                    e_send = 1'b1;
                    m_phase = 1;
                    m_age = 0;
                end
            end else if (m_phase == 1) begin
                if (!tx_sent) begin
                    e_send = 1'b0; m_phase = 2;
                end else if (m_age + 1 >= LT) begin
                    e_send = 1'b0; e_err = 1'b1; m_phase = 0;
                end else begin
                    m_age++;
                end
            end else begin
                if (tx_sent) m_phase = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst && cmp_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("tx_send", 32'(tx_send), 32'(e_send));
            chk("tx_data", 32'(tx_data), 32'(e_data));
            chk("grant_id", 32'(grant_id), 32'(e_gid));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("err_timeout", 32'(err_timeout), 32'(e_err));
        end
    end

    task automatic wait_ready(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_ready_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_idle(input string tag, output int sends, output int errs);
        bit ok = 0;
        sends = int'(tx_send);
        errs  = int'(err_timeout);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_send) sends++;
            if (err_timeout) errs++;
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_idle_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_frame(input string tag);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && !tx_send) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_frame_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(0));
        chk({tag, "_send"}, 32'(tx_send), 32'(0));
        chk({tag, "_data"}, 32'(tx_data), 32'(0));
        chk({tag, "_gid"}, 32'(grant_id), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_err"}, 32'(err_timeout), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cmp_en = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sends, errs, stray;
        logic [1:0]    gids [5];
        logic [DW-1:0] dats [5];
        logic [1:0]    exp_g [5];
        logic [DW-1:0] exp_d [5];

        reset_pulse("rst0");

        // Single requester, core drops tx_sent after 2 cycles
        drop_dly = 2; done_dly = 20;
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        wait_ready("t1");
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_busy", 32'(busy), 32'h1);
        req_valid = '0;
        wait_idle("t1", sends, errs);
        chk("t1_send_cycles", 32'(sends), 32'd2);
        chk("t1_err", 32'(errs), 32'd0);

        // Strict rotation with all four valid
        reset_pulse("rst1");
        drop_dly = 1; done_dly = 5;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ready("t2");
            gids[i] = grant_id;
            dats[i] = tx_data;
        end
        req_valid = '0;
        wait_idle("t2", sends, errs);
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_gid%0d", i), 32'(gids[i]), 32'(exp_g[i]));
            chk($sformatf("t2_data%0d", i), 32'(dats[i]), 32'(exp_d[i]));
        end

        // last_grant=1 then 4'b1001: 3 before 0
        req_valid = 4'b0010;
        wait_ready("t3a");
        chk("t3_gid_a", 32'(grant_id), 32'd1);
        req_valid = '0;
        wait_idle("t3a", sends, errs);
        req_valid = 4'b1001;
        wait_ready("t3b");
        chk("t3_gid_b", 32'(grant_id), 32'd3);
        wait_ready("t3c");
        chk("t3_gid_c", 32'(grant_id), 32'd0);
        req_valid = '0;
        wait_idle("t3c", sends, errs);

        // Launch timeout: core never acknowledges
        hang = 1;
        req_valid = 4'b0001;
        wait_ready("t4");
        req_valid = '0;
        wait_idle("t4", sends, errs);
        chk("t4_send_cycles", 32'(sends), 32'd16);
        chk("t4_err_pulses", 32'(errs), 32'd1);
        hang = 0;
        req_valid = 4'b0100;
        wait_ready("t4b");
        chk("t4_next_gid", 32'(grant_id), 32'd2);
        req_valid = '0;
        wait_idle("t4b", sends, errs);
        chk("t4_next_err", 32'(errs), 32'd0);

        // arb_en falls mid-frame with requester 2 pending
        done_dly = 8;
        req_valid = 4'b0001;
        wait_ready("t5");
        req_valid = '0;
        wait_frame("t5");
        arb_en = 1'b0;
        req_valid = 4'b0100;
        wait_idle("t5", sends, errs);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_ready != '0) stray++;
        end
        chk("t5_no_grant_while_disabled", 32'(stray), 32'd0);
        arb_en = 1'b1;
        @(negedge clk);
        chk("t5_ready_after_enable", 32'(req_ready), 32'b0100);
        chk("t5_gid", 32'(grant_id), 32'd2);
        req_valid = '0;
        wait_idle("t5b", sends, errs);

        // Async reset during WAIT_DONE; requester 0 first afterwards
        req_valid = 4'b0010;
        wait_ready("t6");
        chk("t6_gid", 32'(grant_id), 32'd1);
        wait_frame("t6");
        req_valid = 4'b1111;
        reset_pulse("t6_rst");
        @(negedge clk);
        chk("t6_ready_post", 32'(req_ready), 32'b0001);
        chk("t6_gid_post", 32'(grant_id), 32'd0);
        req_valid = '0;
        wait_idle("t6", sends, errs);

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!cbusy && !tx_send) begin
                drop_dly = $urandom_range(1, 4);
                done_dly = $urandom_range(1, 8);
                hang = ($urandom_range(0, 19) == 0);
            end
            arb_en    = ($urandom_range(0, 9) != 0);
            req_valid = NR'($urandom);
            req_data  = {$urandom};
        end
        arb_en = 1'b1;
        req_valid = '0;
        hang = 0;
        wait_idle("rand", sends, errs);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
